// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional skid entry so that in_ready_o never depends combinationally on out_ready_i.
module pipe_stage_hs #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 64,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire, out_fire;

  assign out_valid_o = (state_q != EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      // Flush drops any incoming beat; data payloads are left untouched.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end else if (in_fire && (SKID != 0)) begin
            state_d     = TWO;
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      // Registered ready: looks only at where the stage is heading, never at out_ready_i.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
          in_ready_q  <= 1'b0;
        end else begin
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
          in_ready_q  <= (state_d != TWO);
        end
      end

      assign in_ready_o = in_ready_q;
    end else begin : g_noskid
      assign skid_ctrl_q = '0;
      assign skid_data_q = '0;
      assign in_ready_o  = rst_n & (~out_valid_o | out_ready_i);
    end
  endgenerate

  assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
  assign out_data_o  = main_data_q;
  assign occupancy_o = {state_q == TWO, state_q == ONE};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: a vector table for streaming, back-pressure and
// flush, plus hand-written reset and SKID=0 sequences.
module tb_pipe_stage_hs;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [15:0] inCtrl;
  logic [63:0] inData;
  logic        outValid;
  logic        outReady;
  logic [15:0] outCtrl;
  logic [63:0] outData;
  logic [1:0]  occ;

  logic        flush0;
  logic        inValid0;
  logic        inReady0;
  logic [15:0] inCtrl0;
  logic [63:0] inData0;
  logic        outValid0;
  logic        outReady0;
  logic [15:0] outCtrl0;
  logic [63:0] outData0;
  logic [1:0]  occ0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        inValid;
    logic [15:0] inCtrl;
    logic        outReady;
    logic        flush;
    logic        expValid;
    logic [15:0] expCtrl;
    logic [1:0]  expOcc;
    logic        expReady;
  } vec_t;

  vec_t vecs[$];

  pipe_stage_hs #(.CTRL_W(16), .DATA_W(64), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(inValid), .in_ready_o(inReady), .in_ctrl_i(inCtrl), .in_data_i(inData),
    .out_valid_o(outValid), .out_ready_i(outReady), .out_ctrl_o(outCtrl),
    .out_data_o(outData), .occupancy_o(occ)
  );

  pipe_stage_hs #(.CTRL_W(16), .DATA_W(64), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush0),
    .in_valid_i(inValid0), .in_ready_o(inReady0), .in_ctrl_i(inCtrl0), .in_data_i(inData0),
    .out_valid_o(outValid0), .out_ready_i(outReady0), .out_ctrl_o(outCtrl0),
    .out_data_o(outData0), .occupancy_o(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] c, input logic ordy, input logic fl);
    inValid  = v;
    inCtrl   = c;
    inData   = 64'hD000 | {48'd0, c};
    outReady = ordy;
    flush    = fl;
  endtask

  task automatic addVec(input logic v, input logic [15:0] c, input logic ordy, input logic fl,
                        input logic ev, input logic [15:0] ec, input logic [1:0] eo, input logic er);
    vec_t t;
    t.inValid = v; t.inCtrl = c; t.outReady = ordy; t.flush = fl;
    t.expValid = ev; t.expCtrl = ec; t.expOcc = eo; t.expReady = er;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Streaming: one beat per cycle, each visible the cycle after acceptance.
    for (int c = 1; c <= 8; c++) addVec(1, 16'(c), 1, 0, 1, 16'(c), 2'd1, 1);
    addVec(0, 16'h0, 1, 0, 0, 16'h0, 2'd0, 1);
    // Back-pressure: 3 held, 4 goes to skid, 5 waits, then 3,4,5 in order.
    addVec(1, 16'h3, 1, 0, 1, 16'h3, 2'd1, 1);
    addVec(1, 16'h4, 0, 0, 1, 16'h3, 2'd2, 0);
    addVec(1, 16'h5, 0, 0, 1, 16'h3, 2'd2, 0);
    addVec(1, 16'h5, 1, 0, 1, 16'h4, 2'd1, 1);
    addVec(1, 16'h5, 1, 0, 1, 16'h5, 2'd1, 1);
    addVec(0, 16'h0, 1, 0, 0, 16'h0, 2'd0, 1);
    // Flush in TWO with a competing input beat that must be dropped.
    addVec(1, 16'h11, 0, 0, 1, 16'h11, 2'd1, 1);
    addVec(1, 16'h22, 0, 0, 1, 16'h11, 2'd2, 0);
    addVec(1, 16'h33, 0, 1, 0, 16'h0,  2'd0, 1);
    addVec(0, 16'h0,  1, 0, 0, 16'h0,  2'd0, 1);
    // Flush in ONE together with out_fire and in_valid; flush while EMPTY.
    addVec(1, 16'h44, 1, 0, 1, 16'h44, 2'd1, 1);
    addVec(1, 16'h55, 1, 1, 0, 16'h0,  2'd0, 1);
    addVec(0, 16'h0,  1, 1, 0, 16'h0,  2'd0, 1);

    flush0 = 0; inValid0 = 0; inCtrl0 = '0; inData0 = '0; outReady0 = 0;

    // Reset held with in_valid asserted.
    rst_n = 1'b0;
    applyStimulus(1, 16'h7, 1, 0);
    #1;
    checkOutput("rst_valid", {63'd0, outValid}, 64'd0);
    checkOutput("rst_ctrl", {48'd0, outCtrl}, 64'd0);
    checkOutput("rst_data", outData, 64'd0);
    checkOutput("rst_ready", {63'd0, inReady}, 64'd0);
    checkOutput("rst_ready_skid0", {63'd0, inReady0}, 64'd0);
    tick();
    tick();
    checkOutput("rst_valid_held", {63'd0, outValid}, 64'd0);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("rel_ready_before_edge", {63'd0, inReady}, 64'd0);
    tick();
    checkOutput("rel_ready_after_edge", {63'd0, inReady}, 64'd1);
    checkOutput("rel_no_accept", {63'd0, outValid}, 64'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].inValid, vecs[i].inCtrl, vecs[i].outReady, vecs[i].flush);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), {63'd0, outValid}, {63'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_ctrl", i), {48'd0, outCtrl}, {48'd0, vecs[i].expCtrl});
      checkOutput($sformatf("vec%0d_occ", i), {62'd0, occ}, {62'd0, vecs[i].expOcc});
      checkOutput($sformatf("vec%0d_ready", i), {63'd0, inReady}, {63'd0, vecs[i].expReady});
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d_data", i), outData, 64'hD000 | {48'd0, vecs[i].expCtrl});
    end

    // Async reset while in TWO: everything clears before the next edge.
    applyStimulus(1, 16'h61, 0, 0);
    tick();
    applyStimulus(1, 16'h62, 0, 0);
    tick();
    checkOutput("ar_occ_full", {62'd0, occ}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {63'd0, outValid}, 64'd0);
    checkOutput("ar_ctrl", {48'd0, outCtrl}, 64'd0);
    checkOutput("ar_data", outData, 64'd0);
    checkOutput("ar_occ", {62'd0, occ}, 64'd0);
    checkOutput("ar_ready", {63'd0, inReady}, 64'd0);
    tick();
    #2 rst_n = 1'b1;
    #1;
    checkOutput("ar_rel_ready_before", {63'd0, inReady}, 64'd0);
    tick();
    checkOutput("ar_rel_ready_after", {63'd0, inReady}, 64'd1);
    checkOutput("ar_rel_valid", {63'd0, outValid}, 64'd0);
    applyStimulus(1, 16'h63, 1, 0);
    tick();
    checkOutput("ar_restart_ctrl", {48'd0, outCtrl}, 64'h63);
    checkOutput("ar_restart_data", outData, 64'hD063);
    applyStimulus(0, 16'h0, 1, 0);
    tick();

    // SKID=0 build: combinational ready follows out_ready within the cycle.
    inValid0 = 1; inCtrl0 = 16'hA1; inData0 = 64'hA1A1; outReady0 = 0;
    #1;
    checkOutput("s0_ready_empty", {63'd0, inReady0}, 64'd1);
    tick();
    checkOutput("s0_valid", {63'd0, outValid0}, 64'd1);
    checkOutput("s0_ctrl_a1", {48'd0, outCtrl0}, 64'hA1);
    checkOutput("s0_occ", {62'd0, occ0}, 64'd1);
    checkOutput("s0_ready_blocked", {63'd0, inReady0}, 64'd0);
    inCtrl0 = 16'hA2; inData0 = 64'hA2A2;
    tick();
    checkOutput("s0_ctrl_held", {48'd0, outCtrl0}, 64'hA1);
    checkOutput("s0_data_held", outData0, 64'hA1A1);
    outReady0 = 1;
    #1;
    checkOutput("s0_ready_comb", {63'd0, inReady0}, 64'd1);
    tick();
    checkOutput("s0_ctrl_a2", {48'd0, outCtrl0}, 64'hA2);
    checkOutput("s0_data_a2", outData0, 64'hA2A2);
    checkOutput("s0_occ_one", {62'd0, occ0}, 64'd1);
    inValid0 = 0;
    tick();
    checkOutput("s0_drain_valid", {63'd0, outValid0}, 64'd0);
    checkOutput("s0_drain_ctrl", {48'd0, outCtrl0}, 64'd0);
    checkOutput("s0_drain_occ", {62'd0, occ0}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
